mips_cpu_muldiv: RTL and testbench
==================================

Name: mips_cpu_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It is the sequential companion to the single-cycle ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The unit sits beside the ALU in the execute stage. The pipeline stalls on busy and reads HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be even, >= 4)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
op_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO write data
op_b  input  WIDTH  multiplier / divisor
flush  input  1  synchronous abort of the in-flight operation
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, HI/LO updated on the same edge
div_by_zero  output  1  registered flag, set with done when DIV/DIVU had op_b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; all internal counters and accumulators are cleared. Reset mid-operation abandons the operation.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - start=1 with op 0-3: latch the operand magnitudes (absolute values for signed ops) and the result signs, load counter=WIDTH-1, go to CALC. busy=1 from the next cycle.
  - start=1 with op 4 or 5: write op_a to hi (op 4) or lo (op 5) on that edge. Stay in IDLE; no done, busy stays 0.
  - start=1 with op 6 or 7: ignored.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
  - The counter decrements each cycle; at counter=0, go to FIXUP.
- FIXUP:
  - Apply sign correction.
  - Write hi/lo, pulse done=1 for one cycle, update div_by_zero, return to IDLE with busy=0 on the same edge.
- Latency: start accepted on edge k; done=1 and the new hi/lo are visible after edge k+WIDTH+1. A new start is accepted on the cycle done is high.
- start while busy=1: ignored. The bench must not rely on queuing.
- Multiply results: {hi,lo} = full 2*WIDTH-bit product, two's complement for MULT and unsigned for MULTU.
- Divide results: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (DIV), or unsigned (DIVU).
- DIV of the most negative value by -1: lo = the most negative value, hi = 0, no error.
- Divide by zero (DIV or DIVU):
  - Same latency as a normal divide.
  - hi = op_a, lo = all ones, div_by_zero = 1.
  - div_by_zero clears to 0 at the next done of any multiply or divide.
- flush=1 (any state): go to IDLE on the next edge with busy=0 and no done. hi, lo and div_by_zero keep their old values. If flush and start are both high in IDLE, flush wins and the start is dropped.
- done is never high during reset or on the cycle after a flush.

Optional Feature:
MIPS_MULDIV_FAST_MUL_EN
- Defined: MULT and MULTU complete in a single cycle using a combinational product.
  - start is accepted on edge k; hi/lo are written and done=1 after edge k+1.
  - busy stays 0 throughout.
  - Divide is unchanged.
- Not defined: multiply uses the iterative path with WIDTH+1 cycle latency.

Test Plan:
- Reset, then MULT op_a=0xFFFFFFFF op_b=0x00000002 -> done 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MIPS_MULDIV_FAST_MUL_EN: same values, done one cycle after accept, busy never high.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0.
- DIVU 0x00000064 / 0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1. Next MULTU 3x4 -> lo=0x0000000C, hi=0, div_by_zero=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi and lo update one edge after each start, done stays 0. During a busy DIV, a start with MTLO 0x11111111 is ignored and lo keeps its previous value until the divide's done.
- Flush 10 cycles into a MULT -> busy=0 next cycle, no done, hi/lo unchanged. Repeat with rst_n low 5 cycles into a DIV -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_cpu_muldiv.sv
// -----------------------------------------------------------------------------
// mips_cpu_muldiv
//
// Iterative multiply/divide unit with architectural HI/LO registers. Executes
// MULT, MULTU, DIV, DIVU (one radix-2 step per clock) plus MTHI and MTLO.
// Signed operations are done on magnitudes; the signs are re-applied in a
// final FIXUP cycle.
//
// Optional feature macro: MIPS_MULDIV_FAST_MUL_EN
//   When defined, MULT/MULTU use a combinational product that is registered
//   once and written to HI/LO on the following edge (done one cycle after
//   accept, busy stays low). Divide is unchanged. Default build: undefined.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy=0
//   op           0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//   op_a         multiplicand / dividend / MTHI-MTLO data
//   op_b         multiplier / divisor
//   flush        synchronous abort of the in-flight operation
//   busy         high while an iterative operation is in progress
//   done         one-cycle pulse, HI/LO updated on the same edge
//   div_by_zero  set with done when a divide had op_b=0
//   hi, lo       HI and LO registers
// -----------------------------------------------------------------------------
module mips_cpu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIXUP
   } state_t;

   state_t               state;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, remaining dividend / quotient bits}.
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mag;      // multiplicand or divisor magnitude
   logic [CW-1:0]        count;
   logic                 is_div;
   logic                 neg_lo;   // negate product / quotient
   logic                 neg_hi;   // negate remainder
   logic                 dz;       // divisor was zero

   // ---------------------------------------------------------------- decode
   logic             op_is_mul;
   logic             op_is_div;
   logic             op_signed;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;

   assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   // The most negative value maps onto itself, which is its correct unsigned
   // magnitude.
   assign abs_a = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
   assign abs_b = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

   // ------------------------------------------------------------ datapath
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   step_next;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      mul_sum   = '0;
      rem_shift = '0;
      div_diff  = '0;
      step_next = acc;
      if (is_div) begin
         // Restoring step: shift in the next dividend bit, try the subtract,
         // keep it only if it did not borrow.
         rem_shift = acc[2*WIDTH-1:WIDTH-1];
         div_diff  = rem_shift - {1'b0, mag};
         if (div_diff[WIDTH])
            step_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         // Shift-add step: the carry out of the add becomes the new MSB.
         mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
         step_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod_fix = '0;
      fix_hi   = '0;
      fix_lo   = '0;
      if (is_div) begin
         fix_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         // With a zero divisor every trial subtract succeeds, so the
         // remainder is the dividend magnitude; re-signing it yields op_a.
         fix_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
         if (dz)
            fix_lo = '1;
      end else begin
         prod_fix = neg_lo ? -acc : acc;
         fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo   = prod_fix[WIDTH-1:0];
      end
   end

`ifdef MIPS_MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] fast_prod_c;
   logic [2*WIDTH-1:0] fast_prod;
   logic               fast_pend;

   // The low 2*WIDTH bits of the product of the extended operands are the
   // exact signed (or unsigned) product.
   assign ext_a = (op == OP_MULT) ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
   assign ext_b = (op == OP_MULT) ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
   assign fast_prod_c = ext_a * ext_b;
`endif

   // ----------------------------------------------------------- control
   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         acc         <= '0;
         mag         <= '0;
         count       <= '0;
         is_div      <= 1'b0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         dz          <= 1'b0;
`ifdef MIPS_MULDIV_FAST_MUL_EN
         fast_prod   <= '0;
         fast_pend   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef MIPS_MULDIV_FAST_MUL_EN
         fast_pend <= 1'b0;
`endif
         if (flush) begin
            // Abandon everything; HI/LO and the error flag are untouched.
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
                  if (fast_pend) begin
                     hi          <= fast_prod[2*WIDTH-1:WIDTH];
                     lo          <= fast_prod[WIDTH-1:0];
                     done        <= 1'b1;
                     div_by_zero <= 1'b0;
                  end
`endif
                  // A write issued on the same edge as a pending fast result
                  // is the younger instruction, so it is assigned last.
                  if (start) begin
                     if (op == OP_MTHI) begin
                        hi <= op_a;
                     end else if (op == OP_MTLO) begin
                        lo <= op_a;
`ifdef MIPS_MULDIV_FAST_MUL_EN
                     end else if (op_is_mul) begin
                        fast_prod <= fast_prod_c;
                        fast_pend <= 1'b1;
`endif
                     end else if (op_is_mul || op_is_div) begin
                        state  <= S_CALC;
                        busy   <= 1'b1;
                        count  <= CW'(WIDTH - 1);
                        is_div <= op_is_div;
                        neg_lo <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_hi <= op_signed && op_is_div && op_a[WIDTH-1];
                        dz     <= op_is_div && (op_b == '0);
                        acc    <= {{WIDTH{1'b0}}, (op_is_div ? abs_a : abs_b)};
                        mag    <= op_is_div ? abs_b : abs_a;
                     end
                  end
               end
               S_CALC: begin
                  acc   <= step_next;
                  count <= count - 1'b1;
                  if (count == '0)
                     state <= S_FIXUP;
               end
               S_FIXUP: begin
                  hi          <= fix_hi;
                  lo          <= fix_lo;
                  done        <= 1'b1;
                  div_by_zero <= dz;
                  state       <= S_IDLE;
                  busy        <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_muldiv
//
// Scoreboard bench for mips_cpu_muldiv (WIDTH=32). The driver computes each
// expected result with 64-bit integer arithmetic and pushes it with the cycle
// on which done must appear; a monitor pops and compares whenever done is seen.
// Directed cases cover the corner values, then randomized operations follow.
// -----------------------------------------------------------------------------
module tb_mips_cpu_muldiv;

   localparam int W = 32;
`ifdef MIPS_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          flush;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   mips_cpu_muldiv #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .op_a        (op_a),
      .op_b        (op_b),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           done_cyc;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [W-1:0] hi_m = '0;   // committed architectural state
   logic [W-1:0] lo_m = '0;
   logic         dz_m = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain 64-bit integer arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t            r;
      longint          sa = longint'($signed(a));
      longint          sb_v = longint'($signed(b));
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      logic [63:0]     p;
      logic [63:0]     q;
      logic [63:0]     m;
      r.done_cyc = 0;
      r.dz = 1'b0;
      p = '0;
      q = '0;
      m = '0;
      case (o)
         3'd0: p = sa * sb_v;
         3'd1: p = ua * ub;
         3'd2: if (b != 0) begin q = sa / sb_v; m = sa % sb_v; end
         default: if (b != 0) begin q = ua / ub; m = ua % ub; end
      endcase
      if (o <= 3'd1) begin
         r.hi = p[63:32];
         r.lo = p[31:0];
      end else if (b == 0) begin
         r.hi = a;
         r.lo = '1;
         r.dz = 1'b1;
      end else begin
         r.hi = m[31:0];
         r.lo = q[31:0];
      end
      return r;
   endfunction

   // ------------------------------------------------------------- monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         if (done) check("done_in_reset", {63'd0, done}, 64'd0);
      end else if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("hi", {32'd0, hi}, {32'd0, e.hi});
            check("lo", {32'd0, lo}, {32'd0, e.lo});
            check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
         end
      end
   end

   // -------------------------------------------------------------- driver
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   // Present one request for exactly one clock edge, starting at a negedge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, output exp_t e);
      wait_idle();
      e = model(o, a, b);
      e.done_cyc = cyc + 1 + ((o <= 3'd1) ? MUL_LAT : DIV_LAT);
      if (push) sb.push_back(e);
      start = 1'b1;
      op    = o;
      op_a  = a;
      op_b  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      issue(o, a, b, 1'b1, e);
      wait_drain();
      hi_m = e.hi;
      lo_m = e.lo;
      dz_m = e.dz;
   endtask

   task automatic mt(input logic [2:0] o, input logic [W-1:0] a);
      exp_t e;
      issue(o, a, '0, 1'b0, e);
      if (o == 3'd4) hi_m = a;
      else           lo_m = a;
      check("mt_hi", {32'd0, hi}, {32'd0, hi_m});
      check("mt_lo", {32'd0, lo}, {32'd0, lo_m});
      check("mt_busy", {63'd0, busy}, 64'd0);
   endtask

   function automatic logic [W-1:0] pick_val();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = 32'd1;
         2:       v = '1;
         3:       v = 32'h8000_0000;
         4:       v = 32'h7fff_ffff;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = '0;
      op_a  = '0;
      op_b  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_dz", {63'd0, div_by_zero}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed corner values
      run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd3, 32'h0000_0064, 32'h0000_0000);
      run_op(3'd1, 32'h0000_0003, 32'h0000_0004);
      run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0000);
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000);

      mt(3'd4, 32'h1234_5678);
      mt(3'd5, 32'h9ABC_DEF0);

      // MTLO presented while a divide is busy must be ignored.
      issue(3'd2, 32'd100, 32'd7, 1'b1, e);
      start = 1'b1;
      op    = 3'd5;
      op_a  = 32'h1111_1111;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_during_div", {63'd0, busy}, 64'd1);
      check("lo_hold_while_busy", {32'd0, lo}, {32'd0, lo_m});
      wait_drain();
      hi_m = e.hi;
      lo_m = e.lo;
      dz_m = e.dz;

      // Flush 10 cycles into a multiply: no done, state unchanged.
      issue(3'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, e);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      check("flush_hi", {32'd0, hi}, {32'd0, hi_m});
      check("flush_lo", {32'd0, lo}, {32'd0, lo_m});
      check("flush_dz", {63'd0, div_by_zero}, {63'd0, dz_m});
      repeat (40) @(negedge clk);

      // Flush and start together in IDLE: the start is dropped.
      start = 1'b1;
      flush = 1'b1;
      op    = 3'd4;
      op_a  = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_hi", {32'd0, hi}, {32'd0, hi_m});
      check("flush_start_busy", {63'd0, busy}, 64'd0);

      // Asynchronous reset 5 cycles into a divide.
      issue(3'd2, 32'h0000_0FFF, 32'h0000_0003, 1'b0, e);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", {63'd0, busy}, 64'd0);
      check("async_rst_done", {63'd0, done}, 64'd0);
      check("async_rst_dz", {63'd0, div_by_zero}, 64'd0);
      check("async_rst_hi", {32'd0, hi}, 64'd0);
      check("async_rst_lo", {32'd0, lo}, 64'd0);
      hi_m = '0;
      lo_m = '0;
      dz_m = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      repeat (40) @(negedge clk);

      // Randomized operations
      for (int i = 0; i < 60; i++) begin
         logic [2:0]   o;
         logic [W-1:0] a;
         logic [W-1:0] b;
         o = 3'($urandom_range(0, 5));
         a = pick_val();
         b = pick_val();
         if (o >= 3'd4) mt(o, a);
         else           run_op(o, a, b);
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
